// File: rtl/cla_sub_seq.sv
// Sequential unsigned subtractor: a - b - bin, one 4-bit carry-lookahead nibble per cycle,
// LSB first, with the borrow chained through a register. Valid/ready on both ports.
module cla_sub_seq #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero
);

   localparam int unsigned N  = WIDTH / 4;
   localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e           state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             zero_q, zero_d;
   logic [KW-1:0]    k_q, k_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;

   logic [3:0]       a_nib, nb_nib, p, g, d_nib;
   logic [4:0]       c;
   logic [WIDTH-1:0] res_nib;
   logic             last;

   // Subtraction as a + ~b + carry, where the incoming carry is the inverted borrow.
   always_comb begin
      a_nib  = a_q[{k_q, 2'b00} +: 4];
      nb_nib = ~b_q[{k_q, 2'b00} +: 4];
      p      = a_nib ^ nb_nib;
      g      = a_nib & nb_nib;
      c[0]   = carry_q;
      c[1]   = g[0] | (p[0] & c[0]);
      c[2]   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3]   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      c[4]   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c[0]);
      d_nib  = p ^ c[3:0];
      res_nib = res_q;
      res_nib[{k_q, 2'b00} +: 4] = d_nib;
      last   = (k_q == KW'(N - 1));
   end

   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      diff_d      = diff_q;
      bout_d      = bout_q;
      zero_d      = zero_q;
      k_d         = k_q;
      carry_d     = carry_q;
      a_d         = a_q;
      b_d         = b_q;
      res_d       = res_q;
      unique case (state_q)
         StIdle: begin
            // in_ready comes up one edge after reset release.
            if (!in_ready_q) begin
               in_ready_d = 1'b1;
            end else if (in_valid) begin
               state_d    = StBusy;
               a_d        = a;
               b_d        = b;
               carry_d    = ~bin;
               k_d        = '0;
               in_ready_d = 1'b0;
            end
         end
         StBusy: begin
            res_d   = res_nib;
            carry_d = c[4];
            k_d     = k_q + 1'b1;
            if (last) begin
               state_d     = StDone;
               k_d         = '0;
               diff_d      = res_nib;
               bout_d      = ~c[4];
               zero_d      = (res_nib == '0);
               out_valid_d = 1'b1;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d     = StIdle;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         diff_q      <= '0;
         bout_q      <= 1'b0;
         zero_q      <= 1'b0;
         k_q         <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         diff_q      <= diff_d;
         bout_q      <= bout_d;
         zero_q      <= zero_d;
         k_q         <= k_d;
         carry_q     <= carry_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_q       <= res_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign bout      = bout_q;
   assign zero      = zero_q;

endmodule
